// File: rtl/simple_cpu_pkg.sv
// simple_cpu_pkg: shared widths and fetch FSM state encoding
package simple_cpu_pkg;
    localparam int INST_W = 23;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 2 ** ADDR_W;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} fetch_state_t;
endpackage

// File: rtl/prog_ram.sv
// prog_ram: program store with one synchronous write and one synchronous read port
module prog_ram
    import simple_cpu_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [INST_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [INST_W-1:0] rd_data
);
    logic [INST_W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: program loader and PC/fetch stage feeding the controller
module fetch_unit
    import simple_cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic [INST_W-1:0] program_in,
    input  logic              start,
    input  logic              inc_pc,
    input  logic              branch,
    input  logic [DATA_W-1:0] bus,
    output logic [INST_W-1:0] code,
    output logic              code_valid,
    output logic [ADDR_W-1:0] address,
    output logic [ADDR_W:0]   prog_len,
    output logic              overflow,
    output logic              done
);
    fetch_state_t      state, state_nx;
    logic [ADDR_W:0]   next_pc;
    logic [INST_W-1:0] ram_q;
    logic              new_load, load_full, we;
    logic [ADDR_W-1:0] rd_addr;
    always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
    always_comb begin
        next_pc = branch ? {1'b0, bus[ADDR_W-1:0]} :
                  inc_pc ? {1'b0, address} + (ADDR_W+1)'(1) : {1'b0, address};
        state_nx = state;
        case (state)
            IDLE: state_nx = write ? LOAD : start ? DONE : IDLE;
            LOAD: state_nx = (start && !write) ? RUN : LOAD;
            RUN:  state_nx = (next_pc >= prog_len) ? DONE : RUN;
            DONE: state_nx = write ? LOAD : (start && prog_len != '0) ? RUN : DONE;
            default: state_nx = IDLE;
        endcase
    end
    // prog_len is DEPTH exactly when its top bit is set
    assign new_load  = write && (state == IDLE || state == DONE);
    assign load_full = write && state == LOAD && prog_len[ADDR_W];
    assign we        = new_load || (write && state == LOAD && !prog_len[ADDR_W]);
    assign rd_addr   = (state == RUN) ? next_pc[ADDR_W-1:0] : '0;
    always_ff @(posedge clk) begin
        if (reset) begin
            address  <= '0;
            prog_len <= '0;
            overflow <= 1'b0;
        end else begin
            if (state != RUN && state_nx == RUN) address <= '0;
            else if (state == RUN && state_nx == RUN) address <= next_pc[ADDR_W-1:0];
            prog_len <= new_load ? (ADDR_W+1)'(1) : we ? prog_len + (ADDR_W+1)'(1) : prog_len;
            overflow <= new_load ? 1'b0 : load_full ? 1'b1 : overflow;
        end
    end
    prog_ram u_ram (
        .clk     (clk),
        .we      (we),
        .wr_addr (new_load ? '0 : prog_len[ADDR_W-1:0]),
        .wr_data (program_in),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );
    assign code_valid = state == RUN;
    assign code       = code_valid ? ram_q : '0;
    assign done       = state == DONE;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of load, run, branch, overflow and reset behaviour
module tb_fetch_unit;
    import simple_cpu_pkg::*;
    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              write = 1'b0;
    logic [INST_W-1:0] program_in = '0;
    logic              start = 1'b0;
    logic              inc_pc = 1'b0;
    logic              branch = 1'b0;
    logic [DATA_W-1:0] bus = '0;
    logic [INST_W-1:0] code;
    logic              code_valid;
    logic [ADDR_W-1:0] address;
    logic [ADDR_W:0]   prog_len;
    logic              overflow;
    logic              done;
    int checks = 0;
    int failures = 0;

    fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .write      (write),
        .program_in (program_in),
        .start      (start),
        .inc_pc     (inc_pc),
        .branch     (branch),
        .bus        (bus),
        .code       (code),
        .code_valid (code_valid),
        .address    (address),
        .prog_len   (prog_len),
        .overflow   (overflow),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [INST_W-1:0] d);
        write = 1'b1;
        program_in = d;
        tick();
        write = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        chk("rst_address", 32'(address), 0);
        chk("rst_code", 32'(code), 0);
        chk("rst_valid", 32'(code_valid), 0);
        chk("rst_len", 32'(prog_len), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_done", 32'(done), 0);

        // empty program: start from IDLE lands in DONE, restart stays there
        go();
        chk("empty_done", 32'(done), 1);
        chk("empty_valid", 32'(code_valid), 0);
        go();
        chk("empty_restart_done", 32'(done), 1);
        chk("empty_restart_valid", 32'(code_valid), 0);

        // load three words and step through them
        wr(23'h000011);
        wr(23'h000022);
        wr(23'h000033);
        chk("l3_len", 32'(prog_len), 3);
        go();
        chk("l3_valid0", 32'(code_valid), 1);
        chk("l3_addr0", 32'(address), 0);
        chk("l3_code0", 32'(code), 32'h11);
        inc_pc = 1'b1;
        tick();
        chk("l3_addr1", 32'(address), 1);
        chk("l3_code1", 32'(code), 32'h22);
        tick();
        chk("l3_addr2", 32'(address), 2);
        chk("l3_code2", 32'(code), 32'h33);
        tick();
        inc_pc = 1'b0;
        chk("l3_done", 32'(done), 1);
        chk("l3_valid_end", 32'(code_valid), 0);
        chk("l3_code_end", 32'(code), 0);
        chk("l3_addr_end", 32'(address), 2);

        // 8-word program; write+start in LOAD keeps loading
        wr(23'h000100);
        start = 1'b1;
        wr(23'h000101);
        start = 1'b0;
        chk("ws_len", 32'(prog_len), 2);
        chk("ws_valid", 32'(code_valid), 0);
        chk("ws_done", 32'(done), 0);
        for (int i = 2; i < 8; i++) wr(23'h000100 + INST_W'(i));
        chk("l8_len", 32'(prog_len), 8);
        go();
        chk("l8_code0", 32'(code), 32'h100);
        inc_pc = 1'b1;
        tick();
        tick();
        inc_pc = 1'b0;
        chk("l8_addr2", 32'(address), 2);
        write = 1'b1;
        program_in = 23'h7FFFFF;
        tick();
        write = 1'b0;
        chk("run_write_len", 32'(prog_len), 8);
        chk("run_hold_addr", 32'(address), 2);
        chk("run_hold_code", 32'(code), 32'h102);
        branch = 1'b1;
        inc_pc = 1'b1;
        bus = 16'h0005;
        tick();
        chk("br_prio_addr", 32'(address), 5);
        chk("br_prio_code", 32'(code), 32'h105);
        bus = 16'hFF07;
        tick();
        branch = 1'b0;
        chk("br_hibits_addr", 32'(address), 7);
        chk("br_hibits_code", 32'(code), 32'h107);
        tick();
        inc_pc = 1'b0;
        chk("l8_done", 32'(done), 1);
        chk("l8_addr_end", 32'(address), 7);

        // 4-word program, branch beyond prog_len
        for (int i = 0; i < 4; i++) wr(23'h000200 + INST_W'(i));
        go();
        inc_pc = 1'b1;
        tick();
        inc_pc = 1'b0;
        chk("l4_addr1", 32'(address), 1);
        branch = 1'b1;
        bus = 16'h0009;
        tick();
        branch = 1'b0;
        chk("br_oor_done", 32'(done), 1);
        chk("br_oor_valid", 32'(code_valid), 0);
        chk("br_oor_addr", 32'(address), 1);
        go();
        chk("rerun_valid", 32'(code_valid), 1);
        chk("rerun_addr", 32'(address), 0);
        chk("rerun_code", 32'(code), 32'h200);
        branch = 1'b1;
        bus = 16'h0003;
        tick();
        branch = 1'b0;
        chk("rerun_addr3", 32'(address), 3);
        chk("rerun_code3", 32'(code), 32'h203);

        // reset mid-run, then reload a single word
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_addr", 32'(address), 0);
        chk("mid_rst_code", 32'(code), 0);
        chk("mid_rst_valid", 32'(code_valid), 0);
        chk("mid_rst_len", 32'(prog_len), 0);
        chk("mid_rst_done", 32'(done), 0);
        wr(23'h07ABCD);
        go();
        chk("post_rst_code", 32'(code), 32'h7ABCD);
        chk("post_rst_valid", 32'(code_valid), 1);
        inc_pc = 1'b1;
        tick();
        inc_pc = 1'b0;
        chk("post_rst_done", 32'(done), 1);

        // overflow: 65 writes, run to the last word, no wrap
        for (int i = 0; i < 64; i++) wr(23'h000300 + INST_W'(i));
        chk("full_len", 32'(prog_len), 64);
        chk("full_no_ovf", 32'(overflow), 0);
        wr(23'h000340);
        chk("ovf_len", 32'(prog_len), 64);
        chk("ovf_flag", 32'(overflow), 1);
        go();
        chk("ovf_code0", 32'(code), 32'h300);
        inc_pc = 1'b1;
        for (int i = 0; i < 63; i++) tick();
        chk("ovf_addr63", 32'(address), 63);
        chk("ovf_code63", 32'(code), 32'h33F);
        tick();
        inc_pc = 1'b0;
        chk("nowrap_done", 32'(done), 1);
        chk("nowrap_addr", 32'(address), 63);
        chk("nowrap_code", 32'(code), 0);
        wr(23'h000001);
        chk("reload_ovf_clr", 32'(overflow), 0);
        chk("reload_len", 32'(prog_len), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program store and instruction fetch stage that sits directly upstream of the controller. It accepts a program word by word on `program_in` while `write` is high and holds it in an internal RAM. After `start`, it presents one instruction per cycle on `code` at the program counter `address`, advancing on `inc_pc` or jumping on `branch` to the target carried on `bus`. It replaces the top-level program-counter function and drives the controller's `code` input.

## Interface
- `INST_W`, 23: instruction width.
- `ADDR_W`, 6: program-counter width.
- `DEPTH`, 64: program words; must equal 2**ADDR_W.
- `DATA_W`, 16: bus width; branch target is `bus[ADDR_W-1:0]`.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: reset is synchronous and active-high.
- `write` in 1: store `program_in` this cycle.
- `program_in` in INST_W: program word to store.
- `start` in 1: begin execution from address 0.
- `inc_pc` in 1: advance PC by one (from controller).
- `branch` in 1: load PC from `bus` (from controller).
- `bus` in DATA_W: datapath bus; branch target source.
- `code` out INST_W: instruction at `address`; 0 when not running.
- `code_valid` out 1: high only in RUN.
- `address` out ADDR_W: current PC.
- `prog_len` out ADDR_W+1: number of stored words, 0..DEPTH.
- `overflow` out 1: sticky; a write was dropped because the RAM was full.
- `done` out 1: high in DONE.

## Operation
- States: IDLE, LOAD, RUN, DONE.
- Reset: state IDLE; `address`=0, `code`=0, `code_valid`=0, `prog_len`=0, `overflow`=0, `done`=0. RAM contents are not cleared.
- IDLE:
  - `write` -> store at 0, `prog_len`=1, go to LOAD.
  - `start` with `write`=0 -> go to DONE (empty program).
- LOAD:
  - `write` with `prog_len`<DEPTH -> store at `prog_len`, `prog_len`+1.
  - `write` with `prog_len`=DEPTH -> word dropped, `overflow`=1.
  - `start` with `write`=0 -> go to RUN with `address`=0.
- Simultaneous `write` and `start` in IDLE, LOAD or DONE: `write` wins and `start` is ignored.
- RUN:
  - `write` and `start` are ignored.
  - next_pc is computed as: `branch` ? `bus[ADDR_W-1:0]` : `inc_pc` ? `address`+1 (computed in ADDR_W+1 bits) : `address`. `branch` has priority over `inc_pc`.
  - If next_pc >= `prog_len` (this includes 63+1 = 64): go to DONE, `code`=0, `code_valid`=0, `address` holds its last value.
  - Otherwise `address`=next_pc and `code`=mem[next_pc].
- DONE:
  - `write` -> new load: store at 0, `prog_len`=1, `overflow` cleared, go to LOAD.
  - `start` with `prog_len`>0 -> rerun from 0.
  - `start` with `prog_len`=0 -> stay in DONE.
- `reset` in any state, including mid-load or mid-run, returns to the reset values on the next edge.

## Timing
- Write latency: a word written at edge N is readable by the fetch path from edge N+1.
- RAM read is synchronous and addressed by next_pc. As a result, while `code_valid`=1, `code` always equals mem[`address`] in the same cycle, with no bubble.
- Entering RUN: the edge that samples `start` loads `address`=0 and `code`=mem[0], and `code_valid` rises on that edge.
- PC change: `inc_pc` or `branch` sampled at edge N gives the new `address` and `code` after edge N.
- DONE entry: `code_valid` falls on the same edge that would have moved the PC out of range.

## Structure
- Shared package `simple_cpu_pkg` holds:
  - `INST_W`, `ADDR_W`, `DATA_W`, `DEPTH` constants;
  - the `fetch_state_t` enum (IDLE/LOAD/RUN/DONE).
  The controller and datapath import the same package.
- Sub-module `prog_ram`: DEPTH x INST_W, one synchronous write port, one synchronous read port, no reset.
- `fetch_unit` contains the FSM, PC, `prog_len` counter and `overflow` flag.

## Test plan
- Load and run: write 3 words `23'h000011`, `23'h000022`, `23'h000033`, then `start`, then `inc_pc` for 3 cycles -> `code` = 11, 22, 33 at `address` 0, 1, 2; then `done`=1, `code_valid`=0, `code`=0.
- Branch priority: 8-word program; in RUN at `address`=2 assert `branch`=1 and `inc_pc`=1 with `bus`=16'h0005 -> next cycle `address`=5, `code`=mem[5].
- Branch out of range: 4-word program, branch with `bus`=16'h0009 -> DONE on that edge, `address` stays at its old value.
- Overflow and wrap: write 65 words -> `prog_len`=64, `overflow`=1; run incrementing through `address` 63, one more `inc_pc` -> DONE with no wrap to 0.
- Simultaneous and ignored controls: `write`+`start` in LOAD -> word stored, state stays LOAD; `write` during RUN -> `prog_len` unchanged; `start` in IDLE with no writes -> DONE, `code_valid` never rises.
- Reset mid-run: `reset` at `address`=3 -> next cycle IDLE, all outputs 0; a new 1-word load then `start` -> `code`=new word.
